time_set_controller: RTL

- Front-end sequencer for the clock's time/date counters.
- Debounces the three raw push-buttons, runs the edit-mode state machine, and drives the shared 3-bit `mode` bus that the hour/minute/second/day/month/year counters decode.
- Issues single-cycle increment/decrement strobes with hold-to-repeat.
- Provides a blink enable for the field under edit, and times out back to run mode on inactivity.

---
 rtl/time_set_controller.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/time_set_controller.sv
// time_set_controller
//   Front-end sequencer for the clock's time/date counters. Debounces the
//   three raw (active-low) push-buttons, steps the edit-mode state machine,
//   and produces single-cycle inc/dec strobes with hold-to-repeat, a blink
//   enable for the field under edit, and an inactivity timeout back to RUN.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   btn_mode   raw mode button, active-low
//   btn_up     raw up button, active-low
//   btn_down   raw down button, active-low
//   mode       edit-mode code decoded by the counters (000 = RUN)
//   inc_pulse  one-cycle increment strobe for the selected field
//   dec_pulse  one-cycle decrement strobe for the selected field
//   blink      1 = display selected field, 0 = blank it
//   editing    high whenever mode != RUN
module time_set_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000,
  parameter int unsigned TIMEOUT_CYCLES  = 500000000,
  parameter int unsigned BLINK_CYCLES    = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [2:0] mode,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       blink,
  output logic       editing
);

  localparam int unsigned REP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RP_W = $clog2(REP_MAX) + 1;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int BK_W = $clog2(BLINK_CYCLES) + 1;

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] HOLD_LAST = RP_W'(HOLD_CYCLES - 1);
  localparam logic [RP_W-1:0] REP_LAST  = RP_W'(REPEAT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BK_W-1:0] BK_LAST   = BK_W'(BLINK_CYCLES - 1);

  typedef enum logic [2:0] {
    RUN      = 3'b000,
    SET_HOUR = 3'b111,
    SET_MIN  = 3'b110,
    SET_SEC  = 3'b101,
    SET_DAY  = 3'b100,
    SET_MON  = 3'b011,
    SET_YEAR = 3'b010
  } state_t;

  function automatic state_t next_mode(input state_t m);
    case (m)
      RUN:      next_mode = SET_HOUR;
      SET_HOUR: next_mode = SET_MIN;
      SET_MIN:  next_mode = SET_SEC;
      SET_SEC:  next_mode = SET_DAY;
      SET_DAY:  next_mode = SET_MON;
      SET_MON:  next_mode = SET_YEAR;
      default:  next_mode = RUN;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Input conditioning: index 0 = mode, 1 = up, 2 = down (1 = pressed)
  // ---------------------------------------------------------------------
  logic [2:0] btn_raw_pressed;
  logic [2:0] press;   // one-cycle press events
  logic [1:0] held;    // debounced level aligned with press: [0]=up, [1]=down

  assign btn_raw_pressed = ~{btn_down, btn_up, btn_mode};

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic            sync1_q, sync2_q, db_q, db_prev_q, press_q;
    logic [DB_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        db_q      <= 1'b0;
        db_prev_q <= 1'b0;
        press_q   <= 1'b0;
        cnt_q     <= '0;
      end else begin
        sync1_q <= btn_raw_pressed[gi];
        sync2_q <= sync1_q;
        if (sync2_q == db_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DB_LAST) begin
          cnt_q <= '0;
          db_q  <= ~db_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        db_prev_q <= db_q;
        // Registering the edge gives the strobe path its fixed DEBOUNCE+3 latency.
        press_q   <= db_q & ~db_prev_q;
      end
    end

    assign press[gi] = press_q;
    if (gi > 0) begin : g_held
      assign held[gi-1] = db_prev_q;
    end
  end

  // ---------------------------------------------------------------------
  // Mode FSM, repeat engine, timeout and blink
  // ---------------------------------------------------------------------
  state_t          mode_q, mode_d;
  logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic            rep_active_q, rep_active_d;  // first strobe of this hold issued
  logic            rep_fast_q, rep_fast_d;      // past the initial HOLD interval
  logic            lock_q, lock_d;              // hold must be released before strobing
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [BK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic            blink_q, blink_d;
  logic            inc_q, inc_d, dec_q, dec_d;
  logic            want_strobe;
  logic            in_set, one_held, none_held;

  assign in_set    = (mode_q != RUN);
  assign one_held  = held[0] ^ held[1];
  assign none_held = ~(held[0] | held[1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= RUN;
      rep_cnt_q    <= '0;
      rep_active_q <= 1'b0;
      rep_fast_q   <= 1'b0;
      lock_q       <= 1'b0;
      to_cnt_q     <= '0;
      blk_cnt_q    <= '0;
      blink_q      <= 1'b1;
      inc_q        <= 1'b0;
      dec_q        <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      rep_cnt_q    <= rep_cnt_d;
      rep_active_q <= rep_active_d;
      rep_fast_q   <= rep_fast_d;
      lock_q       <= lock_d;
      to_cnt_q     <= to_cnt_d;
      blk_cnt_q    <= blk_cnt_d;
      blink_q      <= blink_d;
      inc_q        <= inc_d;
      dec_q        <= dec_d;
    end
  end

  always_comb begin
    mode_d       = mode_q;
    rep_cnt_d    = rep_cnt_q;
    rep_active_d = rep_active_q;
    rep_fast_d   = rep_fast_q;
    lock_d       = lock_q;
    to_cnt_d     = to_cnt_q;
    blk_cnt_d    = blk_cnt_q;
    blink_d      = blink_q;
    want_strobe  = 1'b0;

    // Repeat engine: strobes only while exactly one of up/down is held.
    if (!one_held) begin
      rep_cnt_d    = '0;
      rep_active_d = 1'b0;
      rep_fast_d   = 1'b0;
      if (none_held) lock_d = 1'b0;
    end else if (!in_set || lock_q) begin
      // A button held in RUN (or after a mode-change conflict) stays
      // silent until it has been released.
      rep_cnt_d    = '0;
      rep_active_d = 1'b0;
      rep_fast_d   = 1'b0;
      lock_d       = 1'b1;
    end else if (!rep_active_q) begin
      // Fresh press, or the survivor of an up+down overlap.
      want_strobe  = 1'b1;
      rep_active_d = 1'b1;
      rep_cnt_d    = '0;
      rep_fast_d   = 1'b0;
    end else if (rep_cnt_q == (rep_fast_q ? REP_LAST : HOLD_LAST)) begin
      want_strobe = 1'b1;
      rep_cnt_d   = '0;
      rep_fast_d  = 1'b1;
    end else begin
      rep_cnt_d = rep_cnt_q + 1'b1;
    end

    // Mode press wins over a coincident strobe.
    if (press[0]) begin
      mode_d = next_mode(mode_q);
      if (want_strobe) begin
        want_strobe  = 1'b0;
        rep_cnt_d    = '0;
        rep_active_d = 1'b0;
        rep_fast_d   = 1'b0;
        lock_d       = 1'b1;
      end
    end

    inc_d = want_strobe & held[0];
    dec_d = want_strobe & held[1];

    // Inactivity timeout.
    if (mode_d == RUN) begin
      to_cnt_d = '0;
    end else if ((mode_d != mode_q) || (|press) || want_strobe) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_LAST) begin
      to_cnt_d = '0;
      mode_d   = RUN;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    // Blink, evaluated against the final next mode.
    if ((mode_d == RUN) || (mode_d != mode_q) || want_strobe) begin
      blink_d   = 1'b1;
      blk_cnt_d = '0;
    end else if (blk_cnt_q == BK_LAST) begin
      blink_d   = ~blink_q;
      blk_cnt_d = '0;
    end else begin
      blk_cnt_d = blk_cnt_q + 1'b1;
    end
  end

  assign mode      = mode_q;
  assign inc_pulse = inc_q;
  assign dec_pulse = dec_q;
  assign blink     = blink_q;
  assign editing   = (mode_q != RUN);

endmodule
